fft_frame_scheduler: RTL and testbench

Shares one 256-point streaming FFT core between the two oscilloscope sample channels (CH0/CH1).
- Sends the one-time FFT configuration word after reset.
- Arbitrates whole frames between channels, round-robin.
- Feeds the granted channel's show-ahead buffer into the FFT AXI4-Stream input, generating tlast.
- Keeps exactly one frame in flight; tags each returning spectrum frame with channel ID and bin index.

---
 rtl/fft_pkg.sv | 26 ++
 rtl/fft_frame_scheduler_if.sv | 59 +++++
 rtl/fft_rr_arb2.sv | 30 +++
 rtl/fft_frame_scheduler.sv | 162 ++++++++++++++++
 tb/tb_fft_frame_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT frame scheduler: FSM states,
// frame geometry defaults, channel IDs and the round-robin pick rule.
package fft_pkg;

    localparam int FRAME_LEN_DEF = 256;
    localparam int CNT_W_DEF     = 8;

    typedef enum logic [1:0] {
        S_CFG   = 2'd0,
        S_IDLE  = 2'd1,
        S_FEED  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    // On a tie the channel that did not win last time is chosen.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
        if (req0 && req1) begin
            return ~last;
        end
        return req1 ? CH1 : CH0;
    endfunction

endpackage

// File: rtl/fft_frame_scheduler_if.sv
// Bundle of the scheduler's channel, FFT stream and result signals.
// The master modport is the scheduler side; slave is its environment.
interface fft_frame_scheduler_if #(
    parameter int DATAIN_WIDTH  = 16,
    parameter int DATAOUT_WIDTH = 32,
    parameter int CNT_W         = 8
);
    logic                       ch0_frame_rdy;
    logic [DATAIN_WIDTH-1:0]    ch0_data;
    logic                       ch0_rd_en;
    logic                       ch1_frame_rdy;
    logic [DATAIN_WIDTH-1:0]    ch1_data;
    logic                       ch1_rd_en;

    logic                       cfg_tvalid;
    logic                       cfg_tdata;
    logic                       cfg_tready;

    logic                       fft_in_tvalid;
    logic [2*DATAIN_WIDTH-1:0]  fft_in_tdata;
    logic                       fft_in_tlast;
    logic                       fft_in_tready;

    logic                       fft_out_tvalid;
    logic [2*DATAOUT_WIDTH-1:0] fft_out_tdata;
    logic                       fft_out_tlast;

    logic                       res_valid;
    logic [DATAOUT_WIDTH-1:0]   res_re;
    logic [DATAOUT_WIDTH-1:0]   res_im;
    logic [CNT_W-1:0]           res_idx;
    logic                       res_ch;
    logic                       res_sop;
    logic                       res_eop;
    logic                       frame_err;
    logic                       busy;

    modport master (
        input  ch0_frame_rdy, ch0_data, ch1_frame_rdy, ch1_data,
        input  cfg_tready, fft_in_tready,
        input  fft_out_tvalid, fft_out_tdata, fft_out_tlast,
        output ch0_rd_en, ch1_rd_en,
        output cfg_tvalid, cfg_tdata,
        output fft_in_tvalid, fft_in_tdata, fft_in_tlast,
        output res_valid, res_re, res_im, res_idx, res_ch, res_sop, res_eop,
        output frame_err, busy
    );

    modport slave (
        output ch0_frame_rdy, ch0_data, ch1_frame_rdy, ch1_data,
        output cfg_tready, fft_in_tready,
        output fft_out_tvalid, fft_out_tdata, fft_out_tlast,
        input  ch0_rd_en, ch1_rd_en,
        input  cfg_tvalid, cfg_tdata,
        input  fft_in_tvalid, fft_in_tdata, fft_in_tlast,
        input  res_valid, res_re, res_im, res_idx, res_ch, res_sop, res_eop,
        input  frame_err, busy
    );
endinterface

// File: rtl/fft_rr_arb2.sv
// Two-requester round-robin arbiter. The last-grant register doubles as
// the current grant, so it stays stable for the whole frame once latched.
module fft_rr_arb2
    import fft_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic       any_req,
    output logic       gnt
);

    logic last_reg;
    logic pick;

    assign any_req = |req;
    assign pick    = rr_pick(req[0], req[1], last_reg);
    assign gnt     = last_reg;

    // Reset to CH1 so CH0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg <= CH1;
        end else if (en && any_req) begin
            last_reg <= pick;
        end
    end

endmodule

// File: rtl/fft_frame_scheduler.sv
// Time-shares one streaming FFT between two sample channels: configures the
// core once, feeds whole frames round-robin and tags the returning bins.
module fft_frame_scheduler
    import fft_pkg::*;
#(
    parameter int DATAIN_WIDTH  = 16,
    parameter int DATAOUT_WIDTH = 32,
    parameter int FRAME_LEN     = FRAME_LEN_DEF,
    parameter int CNT_W         = CNT_W_DEF,
    parameter int TIMEOUT       = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fft_frame_scheduler_if.master bus
);

    localparam int               WD_W     = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    state_t                     state_reg;
    logic [CNT_W-1:0]           in_cnt_reg;
    logic [CNT_W-1:0]           out_cnt_reg;
    logic [WD_W-1:0]            wd_reg;
    logic                       cfg_tvalid_reg;
    logic                       busy_reg;
    logic                       frame_err_reg;
    logic                       res_valid_reg;
    logic                       res_sop_reg;
    logic                       res_eop_reg;
    logic                       res_ch_reg;
    logic [DATAOUT_WIDTH-1:0]   res_re_reg;
    logic [DATAOUT_WIDTH-1:0]   res_im_reg;
    logic [CNT_W-1:0]           res_idx_reg;

    logic       any_req;
    logic       gnt;
    logic       feeding;
    logic       in_accept;
    logic       in_last;
    logic       out_beat;
    logic [1:0] rd_en;

    fft_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({bus.ch1_frame_rdy, bus.ch0_frame_rdy}),
        .en      (state_reg == S_IDLE),
        .any_req (any_req),
        .gnt     (gnt)
    );

    assign feeding   = (state_reg == S_FEED);
    assign in_accept = feeding && bus.fft_in_tready;
    assign in_last   = feeding && (in_cnt_reg == LAST_IDX);
    assign out_beat  = (state_reg == S_DRAIN) && bus.fft_out_tvalid;

    // Pops follow the FFT handshake directly so a stalled beat is never lost.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_en
        assign rd_en[gi] = in_accept && (gnt == 1'(gi));
    end

    assign bus.ch0_rd_en     = rd_en[0];
    assign bus.ch1_rd_en     = rd_en[1];
    assign bus.fft_in_tvalid = feeding;
    assign bus.fft_in_tlast  = in_last;
    assign bus.fft_in_tdata  = feeding ?
        {{DATAIN_WIDTH{1'b0}}, (gnt == CH1) ? bus.ch1_data : bus.ch0_data} : '0;

    assign bus.cfg_tvalid = cfg_tvalid_reg;
    assign bus.cfg_tdata  = cfg_tvalid_reg;
    assign bus.busy       = busy_reg;
    assign bus.frame_err  = frame_err_reg;
    assign bus.res_valid  = res_valid_reg;
    assign bus.res_re     = res_re_reg;
    assign bus.res_im     = res_im_reg;
    assign bus.res_idx    = res_idx_reg;
    assign bus.res_ch     = res_ch_reg;
    assign bus.res_sop    = res_sop_reg;
    assign bus.res_eop    = res_eop_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_CFG;
            in_cnt_reg     <= '0;
            out_cnt_reg    <= '0;
            wd_reg         <= '0;
            cfg_tvalid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            frame_err_reg  <= 1'b0;
            res_valid_reg  <= 1'b0;
            res_sop_reg    <= 1'b0;
            res_eop_reg    <= 1'b0;
            res_ch_reg     <= 1'b0;
            res_re_reg     <= '0;
            res_im_reg     <= '0;
            res_idx_reg    <= '0;
        end else begin
            frame_err_reg <= 1'b0;
            res_valid_reg <= out_beat;
            res_sop_reg   <= out_beat && (out_cnt_reg == '0);
            res_eop_reg   <= out_beat && bus.fft_out_tlast;
            if (out_beat) begin
                res_re_reg  <= bus.fft_out_tdata[DATAOUT_WIDTH-1:0];
                res_im_reg  <= bus.fft_out_tdata[2*DATAOUT_WIDTH-1:DATAOUT_WIDTH];
                res_idx_reg <= out_cnt_reg;
                res_ch_reg  <= gnt;
            end
            // Output beats outside DRAIN have no frame to belong to.
            if (bus.fft_out_tvalid && state_reg != S_DRAIN) begin
                frame_err_reg <= 1'b1;
            end

            case (state_reg)
                S_CFG: begin
                    if (cfg_tvalid_reg && bus.cfg_tready) begin
                        cfg_tvalid_reg <= 1'b0;
                        busy_reg       <= 1'b0;
                        state_reg      <= S_IDLE;
                    end else begin
                        cfg_tvalid_reg <= 1'b1;
                        busy_reg       <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (any_req) begin
                        in_cnt_reg  <= '0;
                        out_cnt_reg <= '0;
                        busy_reg    <= 1'b1;
                        state_reg   <= S_FEED;
                    end
                end
                S_FEED: begin
                    if (in_accept) begin
                        in_cnt_reg <= in_cnt_reg + 1'b1;
                        if (in_last) begin
                            wd_reg    <= '0;
                            state_reg <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    wd_reg <= wd_reg + 1'b1;
                    if (out_beat) begin
                        out_cnt_reg <= out_cnt_reg + 1'b1;
                    end
                    if (out_beat && bus.fft_out_tlast) begin
                        frame_err_reg <= (out_cnt_reg != LAST_IDX);
                        busy_reg      <= 1'b0;
                        state_reg     <= S_IDLE;
                    end else if (wd_reg == WD_LAST) begin
                        frame_err_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Scoreboard bench: phases push channel frames plus the expected FFT-input
// and result streams; a negedge monitor pops and compares what the DUT emits.
module tb_fft_frame_scheduler;

    localparam int DW = 16;
    localparam int OW = 32;
    localparam int FL = 256;
    localparam int CW = 8;
    localparam int TO = 4096;

    localparam int F_NORMAL = 0;
    localparam int F_EARLY  = 1;
    localparam int F_SILENT = 2;
    localparam int T_ALWAYS = 0;
    localparam int T_TOGGLE = 1;
    localparam int T_RANDOM = 2;
    localparam int EARLY_IDX = 100;

    typedef struct {
        logic          ch;
        logic [DW-1:0] s;
        logic          last;
    } in_exp_t;

    typedef struct {
        logic          ch;
        logic [CW-1:0] idx;
        logic [OW-1:0] re;
        logic [OW-1:0] im;
        logic          sop;
        logic          eop;
        logic          err;
    } res_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_frame_scheduler_if #(.DATAIN_WIDTH(DW), .DATAOUT_WIDTH(OW), .CNT_W(CW)) bus ();

    fft_frame_scheduler #(
        .DATAIN_WIDTH (DW),
        .DATAOUT_WIDTH(OW),
        .FRAME_LEN    (FL),
        .CNT_W        (CW),
        .TIMEOUT      (TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment state: channel buffers and FFT core model
    logic [DW-1:0] chq0[$];
    logic [DW-1:0] chq1[$];
    logic [DW-1:0] fin[$];
    logic [DW-1:0] fbuf[FL];
    int pops_req0 = 0, pops_req1 = 0;
    int frames_in = 0, frames_started = 0;
    int stray_cnt = 0, stray_done = 0;
    int fmode = F_NORMAL;
    int tmode = T_ALWAYS;
    bit emitting = 1'b0;

    // Reference model state and scoreboard queues
    logic [DW-1:0] mq0[$];
    logic [DW-1:0] mq1[$];
    int mdl_last = 1;
    in_exp_t  exp_in[$];
    res_exp_t exp_res[$];
    int err_due[$];
    bit mon_en = 1'b0;

    function automatic logic [OW-1:0] f_re(input logic [DW-1:0] s, input int j);
        return {16'h0, s} * 32'd3 + 32'(j);
    endfunction

    function automatic logic [OW-1:0] f_im(input logic [DW-1:0] s, input int j);
        return {s, 16'h5a5a} ^ (32'(j) << 3);
    endfunction

    function automatic int next_ch(input int n0, input int n1, input int last);
        if (n0 > 0 && n1 > 0) return 1 - last;
        return (n0 > 0) ? 0 : 1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Environment driver: channel buffers, FFT input ready, FFT output model
    initial begin
        int j;
        int last_j;
        bit tog;
        j = 0; last_j = FL - 1; tog = 1'b0;
        bus.ch0_frame_rdy = 1'b0; bus.ch0_data = '0;
        bus.ch1_frame_rdy = 1'b0; bus.ch1_data = '0;
        bus.fft_in_tready = 1'b0;
        bus.fft_out_tvalid = 1'b0; bus.fft_out_tdata = '0; bus.fft_out_tlast = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            while (pops_req0 > 0) begin void'(chq0.pop_front()); pops_req0--; end
            while (pops_req1 > 0) begin void'(chq1.pop_front()); pops_req1--; end
            bus.ch0_frame_rdy = (chq0.size() >= FL);
            bus.ch1_frame_rdy = (chq1.size() >= FL);
            bus.ch0_data = (chq0.size() > 0) ? chq0[0] : '0;
            bus.ch1_data = (chq1.size() > 0) ? chq1[0] : '0;
            tog = ~tog;
            case (tmode)
                T_ALWAYS: bus.fft_in_tready = 1'b1;
                T_TOGGLE: bus.fft_in_tready = tog;
                default:  bus.fft_in_tready = ($urandom_range(0, 2) != 0);
            endcase

            bus.fft_out_tvalid = 1'b0;
            bus.fft_out_tlast  = 1'b0;
            if (!emitting && frames_started < frames_in) begin
                frames_started++;
                for (int k = 0; k < FL; k++) fbuf[k] = fin.pop_front();
                j = 0;
                last_j = (fmode == F_EARLY) ? EARLY_IDX : FL - 1;
                emitting = (fmode != F_SILENT);
            end
            if (emitting) begin
                if ($urandom_range(0, 3) != 0) begin
                    bus.fft_out_tvalid = 1'b1;
                    bus.fft_out_tdata  = {f_im(fbuf[j], j), f_re(fbuf[j], j)};
                    bus.fft_out_tlast  = (j == last_j);
                    if (j == last_j) emitting = 1'b0;
                    j++;
                end
            end else if (stray_done < stray_cnt) begin
                stray_done++;
                bus.fft_out_tvalid = 1'b1;
                bus.fft_out_tdata  = {$urandom, $urandom};
                bus.fft_out_tlast  = 1'( 32'($urandom) & 32'd1);
                err_due.push_back(cyc + 1);
            end
        end
    end

    // Monitor: compares every DUT output event against the scoreboard
    initial begin
        in_exp_t  ei;
        res_exp_t er;
        bit exp_err;
        forever begin
            @(negedge clk);
            if (rst_n && mon_en) begin
                exp_err = 1'b0;
                if (bus.fft_in_tvalid && bus.fft_in_tready) begin
                    if (exp_in.size() == 0) begin
                        chk("fft_in_unexpected", 1, 0);
                    end else begin
                        ei = exp_in.pop_front();
                        chk("fft_in_tdata", bus.fft_in_tdata, {16'h0, ei.s});
                        chk("fft_in_tlast", bus.fft_in_tlast, ei.last);
                        chk("rd_en_accept", {bus.ch1_rd_en, bus.ch0_rd_en}, ei.ch ? 2'b10 : 2'b01);
                    end
                    if (bus.ch0_rd_en) pops_req0++;
                    if (bus.ch1_rd_en) pops_req1++;
                    fin.push_back(bus.fft_in_tdata[DW-1:0]);
                    if (bus.fft_in_tlast) begin
                        frames_in++;
                        if (fmode == F_SILENT) err_due.push_back(cyc + 1 + TO);
                    end
                end else begin
                    chk("rd_en_idle", {bus.ch1_rd_en, bus.ch0_rd_en}, 2'b00);
                end

                if (err_due.size() > 0 && err_due[0] == cyc) begin
                    void'(err_due.pop_front());
                    exp_err = 1'b1;
                    chk("busy_after_err", bus.busy, 1'b0);
                end

                if (bus.res_valid) begin
                    if (exp_res.size() == 0) begin
                        chk("res_unexpected", 1, 0);
                    end else begin
                        er = exp_res.pop_front();
                        chk("res_re", bus.res_re, er.re);
                        chk("res_im", bus.res_im, er.im);
                        chk("res_idx", bus.res_idx, er.idx);
                        chk("res_ch", bus.res_ch, er.ch);
                        chk("res_sop", bus.res_sop, er.sop);
                        chk("res_eop", bus.res_eop, er.eop);
                        if (er.err) exp_err = 1'b1;
                        if (er.eop) $display("result frame ch=%0d last_idx=%0d err=%0d", er.ch, er.idx, er.err);
                    end
                end else begin
                    chk("sop_eop_idle", {bus.res_sop, bus.res_eop}, 2'b00);
                end

                if (exp_err || bus.frame_err) chk("frame_err", bus.frame_err, exp_err);
            end
        end
    end

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (k < 20000 && !(exp_in.size() == 0 && exp_res.size() == 0 && err_due.size() == 0
               && frames_started == frames_in && !emitting && stray_done == stray_cnt
               && bus.busy == 1'b0)) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk({name, "_completes"}, k < 20000, 1'b1);
        $display("phase %s done after %0d cycles", name, k);
    endtask

    task automatic run_phase(input string name, input int n0, input int n1, input bit ramp,
                             input int fm, input int tm);
        int cnt[2];
        int c;
        int nres;
        logic [DW-1:0] s;
        logic [DW-1:0] fr[$];
        fmode = fm;
        tmode = tm;
        for (int f = 0; f < n0; f++)
            for (int k = 0; k < FL; k++) begin
                s = ramp ? DW'(k) : DW'($urandom);
                chq0.push_back(s); mq0.push_back(s);
            end
        for (int f = 0; f < n1; f++)
            for (int k = 0; k < FL; k++) begin
                s = ramp ? DW'(k) : DW'($urandom);
                chq1.push_back(s); mq1.push_back(s);
            end
        cnt[0] = n0; cnt[1] = n1;
        nres = (fm == F_NORMAL) ? FL : (fm == F_EARLY) ? EARLY_IDX + 1 : 0;
        while (cnt[0] + cnt[1] > 0) begin
            c = next_ch(cnt[0], cnt[1], mdl_last);
            mdl_last = c;
            cnt[c]--;
            fr.delete();
            for (int k = 0; k < FL; k++) fr.push_back((c == 1) ? mq1.pop_front() : mq0.pop_front());
            for (int k = 0; k < FL; k++)
                exp_in.push_back('{ch: 1'(c), s: fr[k], last: (k == FL - 1)});
            for (int k = 0; k < nres; k++)
                exp_res.push_back('{ch: 1'(c), idx: CW'(k), re: f_re(fr[k], k), im: f_im(fr[k], k),
                                    sop: (k == 0), eop: (k == nres - 1),
                                    err: (fm == F_EARLY && k == nres - 1)});
        end
        wait_idle(name);
    endtask

    initial begin
        int hi;
        int n0;
        int n1;
        bus.cfg_tready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {bus.cfg_tvalid, bus.cfg_tdata, bus.fft_in_tvalid, bus.fft_in_tlast,
                           bus.ch0_rd_en, bus.ch1_rd_en, bus.res_valid, bus.res_sop, bus.res_eop,
                           bus.res_ch, bus.frame_err, bus.busy}, 12'h000);
        chk("reset_res_re", bus.res_re, 0);
        chk("reset_res_im", bus.res_im, 0);
        chk("reset_res_idx", bus.res_idx, 0);
        chk("reset_fft_in_tdata", bus.fft_in_tdata, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        hi = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.cfg_tvalid) begin
                hi++;
                chk("cfg_tdata", bus.cfg_tdata, 1'b1);
                chk("busy_in_cfg", bus.busy, 1'b1);
                bus.cfg_tready = (hi == 6);
            end else if (hi > 0) begin
                break;
            end
        end
        bus.cfg_tready = 1'b0;
        chk("cfg_valid_cycles", hi, 6);
        chk("busy_after_cfg", bus.busy, 1'b0);
        $display("config handshake after %0d valid cycles", hi);

        @(posedge clk); #3;
        run_phase("ramp_ch0", 1, 0, 1'b1, F_NORMAL, T_ALWAYS);
        @(posedge clk); #3;
        run_phase("timeout_ch1", 0, 1, 1'b0, F_SILENT, T_RANDOM);
        @(posedge clk); #3;
        run_phase("both_ready", 2, 1, 1'b0, F_NORMAL, T_RANDOM);
        @(posedge clk); #3;
        run_phase("toggle_ready", 0, 1, 1'b0, F_NORMAL, T_TOGGLE);
        @(posedge clk); #3;
        run_phase("early_tlast", 1, 0, 1'b0, F_EARLY, T_RANDOM);
        @(posedge clk); #3;
        stray_cnt++;
        wait_idle("stray_beat");
        for (int p = 0; p < 3; p++) begin
            @(posedge clk); #3;
            n0 = $urandom_range(0, 2);
            n1 = $urandom_range(0, 2);
            if (n0 + n1 == 0) n0 = 1;
            run_phase("random_mix", n0, n1, 1'b0, F_NORMAL, T_RANDOM);
        end

        repeat (5) @(negedge clk);
        chk("cfg_stays_low", bus.cfg_tvalid, 1'b0);
        chk("exp_in_empty", exp_in.size(), 0);
        chk("exp_res_empty", exp_res.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "global timeout");
    end

endmodule
